// File: rtl/hyp_shift_sequencer.sv
// hyp_shift_sequencer
//   Emits the scale-constant sequence for an expanded hyperbolic CORDIC run.
//   Negative phase i = -N_NEG..0 gives O_D = 1 - 2^-(|i|+2); positive phase
//   k = 1..N_POS gives O_D = 2^-k. Constants are formed arithmetically from
//   the index (no table). Entries use a VALID/ACK handshake; ABORT returns to
//   IDLE without a DONE pulse.
//   Optional feature macro: HYP_SHIFT_REPEAT_EN -- when defined, indices
//   k in {4,13,40,...} are emitted twice (second copy with REPEAT=1).
// Ports:
//   CLK, RST_N (sync, active-low), START, ACK, ABORT      -- inputs
//   VALID, O_D[P], ITER_IDX[D] (signed), REPEAT, NEG_PHASE,
//   LAST, BUSY, DONE                                       -- outputs
module hyp_shift_sequencer #(
  parameter int P     = 32,
  parameter int D     = 6,
  parameter int N_NEG = 6,
  parameter int N_POS = 20
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                START,
  input  logic                ACK,
  input  logic                ABORT,
  output logic                VALID,
  output logic [P-1:0]        O_D,
  output logic signed [D-1:0] ITER_IDX,
  output logic                REPEAT,
  output logic                NEG_PHASE,
  output logic                LAST,
  output logic                BUSY,
  output logic                DONE
);

  localparam int EW   = (P == 64) ? 11 : 8;
  localparam int MW   = P - 1 - EW;
  localparam int BIAS = (1 << (EW - 1)) - 1;

`ifdef HYP_SHIFT_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_NEG, S_POS, S_FIN} state_t;

  state_t               r_state, w_state_nxt;
  logic signed [D-1:0]  r_idx, w_idx_nxt;
  logic                 r_rep, w_rep_nxt;   // current entry is the second copy

  // Membership in r0=4, r(n+1)=3r(n)+1; stop growing once past k to avoid overflow.
  function automatic logic f_is_rep(input int k);
    int   r;
    logic hit;
    hit = 1'b0;
    r   = 4;
    for (int n = 0; n < 20; n++) begin
      if (r == k) hit = 1'b1;
      if (r <= k) r = 3 * r + 1;
    end
    return hit;
  endfunction

  int   w_k;
  int   w_abs;
  logic w_rep_k;
  logic w_last;
  logic w_valid;
  logic [MW-1:0] w_all1;
  logic [MW-1:0] w_mant_neg;

  always_comb begin
    w_k        = int'(r_idx);
    w_abs      = -w_k;
    w_rep_k    = REP_EN && f_is_rep(w_k);
    w_valid    = (r_state == S_NEG) || (r_state == S_POS);
    // Final emission of N_POS: only the second copy when N_POS is a repeat index.
    w_last     = (r_state == S_POS) && (w_k == N_POS) && (!w_rep_k || r_rep);
    w_all1     = '1;
    // Top |i|+1 mantissa bits set -> 1 - 2^-(|i|+2) with exponent bias-1.
    w_mant_neg = w_all1 << (MW - 1 - w_abs);
  end

  // State register
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_rep   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_rep   <= w_rep_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_rep_nxt   = r_rep;
    case (r_state)
      S_IDLE: if (START) begin
        w_state_nxt = S_NEG;
        w_idx_nxt   = D'(-N_NEG);
        w_rep_nxt   = 1'b0;
      end
      S_NEG: if (ACK) begin
        if (w_k == 0) begin
          w_state_nxt = S_POS;
          w_idx_nxt   = D'(1);
        end else begin
          w_idx_nxt   = D'(w_k + 1);
        end
      end
      S_POS: if (ACK) begin
        if (w_last) begin
          w_state_nxt = S_FIN;
        end else if (w_rep_k && !r_rep) begin
          w_rep_nxt   = 1'b1;
        end else begin
          w_idx_nxt   = D'(w_k + 1);
          w_rep_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
        w_rep_nxt   = 1'b0;
      end
    endcase
    if (ABORT && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = '0;
      w_rep_nxt   = 1'b0;
    end
  end

  // Outputs: every field is zero unless an entry is being presented.
  always_comb begin
    VALID     = w_valid;
    BUSY      = (r_state != S_IDLE);
    DONE      = (r_state == S_FIN);
    O_D       = '0;
    ITER_IDX  = '0;
    REPEAT    = 1'b0;
    NEG_PHASE = 1'b0;
    LAST      = 1'b0;
    case (r_state)
      S_NEG: begin
        O_D       = {1'b0, EW'(BIAS - 1), w_mant_neg};
        ITER_IDX  = r_idx;
        NEG_PHASE = 1'b1;
      end
      S_POS: begin
        O_D      = {1'b0, EW'(BIAS - w_k), MW'(0)};
        ITER_IDX = r_idx;
        REPEAT   = r_rep;
        LAST     = w_last;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hyp_shift_sequencer.sv
module tb_hyp_shift_sequencer;

`ifdef HYP_SHIFT_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif
  localparam int NNEG = 6;
  localparam int NPOS = 20;

  logic CLK = 1'b0, RST_N = 1'b0, START = 1'b0, ACK = 1'b0, ABORT = 1'b0;
  always #5 CLK = ~CLK;

  logic v32, rep32, neg32, last32, busy32, done32;
  logic [31:0] od32;
  logic signed [5:0] idx32;
  logic v64, rep64, neg64, last64, busy64, done64;
  logic [63:0] od64;
  logic signed [5:0] idx64;

  hyp_shift_sequencer #(.P(32), .D(6), .N_NEG(NNEG), .N_POS(NPOS)) dut32 (
    .CLK(CLK), .RST_N(RST_N), .START(START), .ACK(ACK), .ABORT(ABORT),
    .VALID(v32), .O_D(od32), .ITER_IDX(idx32), .REPEAT(rep32),
    .NEG_PHASE(neg32), .LAST(last32), .BUSY(busy32), .DONE(done32));

  hyp_shift_sequencer #(.P(64), .D(6), .N_NEG(NNEG), .N_POS(NPOS)) dut64 (
    .CLK(CLK), .RST_N(RST_N), .START(START), .ACK(ACK), .ABORT(ABORT),
    .VALID(v64), .O_D(od64), .ITER_IDX(idx64), .REPEAT(rep64),
    .NEG_PHASE(neg64), .LAST(last64), .BUSY(busy64), .DONE(done64));

  typedef struct {
    int          idx;
    logic [31:0] od32;
    logic [63:0] od64;
    bit          rep;
    bit          neg;
    bit          last;
  } exp_t;

  typedef struct {
    int          pos;
    int          idx;
    logic [31:0] od32;
    logic [63:0] od64;
    bit          rep;
    bit          last;
  } vec_t;

  exp_t q[$];
  vec_t tbl[$];
  int          cap_idx[$];
  logic [31:0] cap_od32[$];
  logic [63:0] cap_od64[$];
  bit          cap_rep[$];
  bit          cap_last[$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input int idx, input bit neg, input bit rep);
    exp_t e;
    real  v, h;
    logic [63:0] b;
    int   a;
    if (neg) begin
      a = -idx;
      h = 1.0;
      repeat (a + 2) h = h / 2.0;
      v = 1.0 - h;
    end else begin
      v = 1.0;
      repeat (idx) v = v / 2.0;
    end
    b      = $realtobits(v);
    e.idx  = idx;
    e.od64 = b;
    e.od32 = {1'b0, 8'(int'(b[62:52]) - 1023 + 127), b[51:29]};
    e.rep  = rep;
    e.neg  = neg;
    e.last = 1'b0;
    return e;
  endfunction

  task automatic build_q();
    int r;
    bit isr;
    q.delete();
    for (int i = -NNEG; i <= 0; i++) q.push_back(mk(i, 1'b1, 1'b0));
    for (int k = 1; k <= NPOS; k++) begin
      q.push_back(mk(k, 1'b0, 1'b0));
      isr = 1'b0;
      r = 4;
      while (r <= k) begin
        if (r == k) isr = 1'b1;
        r = 3 * r + 1;
      end
      if (REP && isr) q.push_back(mk(k, 1'b0, 1'b1));
    end
    q[q.size()-1].last = 1'b1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, {62'd0, v64, v32}, 64'd0);
    chk({nm, "_od32"}, {32'd0, od32}, 64'd0);
    chk({nm, "_od64"}, od64, 64'd0);
    chk({nm, "_idx"}, {52'd0, idx64, idx32}, 64'd0);
    chk({nm, "_flags"}, {56'd0, rep32, neg32, last32, busy32, rep64, neg64, last64, busy64}, 64'd0);
    chk({nm, "_done"}, {62'd0, done64, done32}, 64'd0);
  endtask

  task automatic chk_entry(input exp_t e);
    chk("idx32", 64'(int'(idx32)), 64'(e.idx));
    chk("idx64", 64'(int'(idx64)), 64'(e.idx));
    chk("od32", {32'd0, od32}, {32'd0, e.od32});
    chk("od64", od64, e.od64);
    chk("flags32", {61'd0, rep32, neg32, last32}, {61'd0, e.rep, e.neg, e.last});
    chk("flags64", {61'd0, rep64, neg64, last64}, {61'd0, e.rep, e.neg, e.last});
    chk("busy_done", {60'd0, busy32, busy64, done32, done64}, 64'hC);
  endtask

  // One sequence: optional ACK stall at index stall_k, random ACK, or abort at abort_k.
  task automatic run(input int stall_k, input int stall_len, input bit rnd_ack,
                     input int abort_k, input bit capture);
    exp_t e;
    int   cyc, stall_cnt;
    bit   ack, aborted;
    build_q();
    cyc = 0; stall_cnt = 0; aborted = 1'b0;
    START = 1'b1;
    tick();
    START = 1'b0;
    while (v32 && cyc < 400) begin
      if (q.size() == 0) begin
        chk("extra_entry", 64'd1, 64'd0);
        break;
      end
      e = q[0];
      chk_entry(e);
      if (abort_k != 0 && int'(idx32) == abort_k && !rep32) begin
        ABORT = 1'b1; ACK = 1'b1;
        tick();
        ABORT = 1'b0;
        chk_zero("abort");
        aborted = 1'b1;
        break;
      end
      ack = rnd_ack ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall_k != 0 && int'(idx32) == stall_k && stall_cnt < stall_len) begin
        ack = 1'b0;
        stall_cnt++;
        chk("stall_hold", {32'd0, od32}, 64'h3E800000);
      end
      ACK = ack;
      tick();
      if (ack) begin
        void'(q.pop_front());
        if (capture) begin
          cap_idx.push_back(e.idx);
          cap_od32.push_back(e.od32);
          cap_od64.push_back(e.od64);
          cap_rep.push_back(e.rep);
          cap_last.push_back(e.last);
        end
      end
      cyc++;
    end
    if (cyc >= 400) chk("timeout", 64'd1, 64'd0);
    if (stall_k != 0) chk("stall_cycles", 64'(stall_cnt), 64'(stall_len));
    if (aborted) begin
      repeat (3) begin
        chk("no_done_after_abort", {62'd0, done64, done32}, 64'd0);
        tick();
      end
    end else begin
      chk("q_empty", 64'(q.size()), 64'd0);
      chk("fin_pulse", {58'd0, done32, done64, busy32, busy64, v32, v64}, 64'h3C);
      tick();
      chk_zero("post_fin");
    end
    ACK = 1'b0;
  endtask

  initial begin
    int n;
    // Reset with START held: ignored while RST_N low.
    RST_N = 1'b0; START = 1'b1; ACK = 1'b1; ABORT = 1'b1;
    repeat (3) tick();
    chk_zero("reset");
    RST_N = 1'b1; START = 1'b0; ABORT = 1'b0;
    tick();
    chk_zero("idle_ack_ignored");

    // Full-throughput run, entries captured for the spot-value table.
    run(0, 0, 1'b0, 0, 1'b1);
    chk("entry_count", 64'(cap_idx.size()), REP ? 64'd29 : 64'd27);

    tbl.push_back(vec_t'{0, -6, 32'h3F7F0000, 64'h3FEFE00000000000, 1'b0, 1'b0});
    tbl.push_back(vec_t'{6,  0, 32'h3F400000, 64'h3FE8000000000000, 1'b0, 1'b0});
    tbl.push_back(vec_t'{7,  1, 32'h3F000000, 64'h3FE0000000000000, 1'b0, 1'b0});
    tbl.push_back(vec_t'{8,  2, 32'h3E800000, 64'h3FD0000000000000, 1'b0, 1'b0});
    tbl.push_back(vec_t'{10, 4, 32'h3D800000, 64'h3FB0000000000000, 1'b0, 1'b0});
`ifdef HYP_SHIFT_REPEAT_EN
    tbl.push_back(vec_t'{11, 4, 32'h3D800000, 64'h3FB0000000000000, 1'b1, 1'b0});
    tbl.push_back(vec_t'{20, 13, 32'h39000000, 64'h3F20000000000000, 1'b0, 1'b0});
    tbl.push_back(vec_t'{21, 13, 32'h39000000, 64'h3F20000000000000, 1'b1, 1'b0});
    tbl.push_back(vec_t'{28, 20, 32'h35800000, 64'h3EB0000000000000, 1'b0, 1'b1});
`else
    tbl.push_back(vec_t'{11, 5, 32'h3D000000, 64'h3FA0000000000000, 1'b0, 1'b0});
    tbl.push_back(vec_t'{19, 13, 32'h39000000, 64'h3F20000000000000, 1'b0, 1'b0});
    tbl.push_back(vec_t'{26, 20, 32'h35800000, 64'h3EB0000000000000, 1'b0, 1'b1});
`endif
    foreach (tbl[t]) begin
      if (tbl[t].pos >= cap_idx.size()) begin
        chk("tbl_missing", 64'(tbl[t].pos), 64'(cap_idx.size()));
      end else begin
        chk("tbl_idx", 64'(cap_idx[tbl[t].pos]), 64'(tbl[t].idx));
        chk("tbl_od32", {32'd0, cap_od32[tbl[t].pos]}, {32'd0, tbl[t].od32});
        chk("tbl_od64", cap_od64[tbl[t].pos], tbl[t].od64);
        chk("tbl_flags", {62'd0, cap_rep[tbl[t].pos], cap_last[tbl[t].pos]},
            {62'd0, tbl[t].rep, tbl[t].last});
      end
    end

    // ACK low for 5 cycles at k=2.
    run(2, 5, 1'b0, 0, 1'b0);
    // Random backpressure.
    run(0, 0, 1'b1, 0, 1'b0);
    // Abort at k=10, then restart from the top.
    run(0, 0, 1'b0, 10, 1'b0);
    run(0, 0, 1'b0, 0, 1'b0);

    // START held through the run: ignored in FIN, honoured in the IDLE after.
    START = 1'b1; ACK = 1'b1;
    tick();
    n = 0;
    while (v32 && n < 100) begin tick(); n++; end
    chk("held_start_done", {62'd0, done32, done64}, 64'h3);
    tick();
    chk("held_start_idle", {62'd0, busy32, v32}, 64'd0);
    tick();
    chk("held_start_restart", {62'd0, v32, v64}, 64'h3);
    chk("held_start_idx", 64'(int'(idx32)), 64'(-6));
    START = 1'b0; ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk_zero("held_start_abort");

    // Reset mid-POS beats START/ABORT/ACK; first START after release is taken.
    START = 1'b1;
    tick();
    START = 1'b0;
    n = 0;
    while (int'(idx32) != 5 && n < 100) begin tick(); n++; end
    chk("reach_k5", 64'(int'(idx32)), 64'd5);
    RST_N = 1'b0; START = 1'b1; ABORT = 1'b1; ACK = 1'b1;
    tick();
    chk_zero("mid_reset");
    ABORT = 1'b0; RST_N = 1'b1;
    tick();
    chk("post_reset_start", {62'd0, v32, v64}, 64'h3);
    chk("post_reset_idx", 64'(int'(idx64)), 64'(-6));
    START = 1'b0; ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk_zero("final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
